// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the select lines of a 4:1 MUX through one channel
// or all four, waits DWELL cycles on each select, samples z, and presents the
// captured 4-bit word (plus a mask of sampled channels) over valid/ready.
module mux_scan_sequencer #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [1:0] ch,
  input  logic       z_in,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [3:0] out_mask
);

  // A zero settle time has no meaning; stop the build instead of misbehaving.
  if (DWELL < 1) begin : g_dwell_check
    $error("mux_scan_sequencer: DWELL must be >= 1");
  end

  localparam int CW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_mode;
  logic [1:0]    r_sel;
  logic          r_busy;
  logic          r_valid;
  logic [3:0]    r_data;
  logic [3:0]    r_mask;
  logic [CW-1:0] r_cnt;

  // Capture sequencer: accept a request, dwell and sample each channel, then hold the word until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= 1'b0;
      r_sel   <= 2'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 4'd0;
      r_mask  <= 4'd0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // sel keeps its last value while idle; only a new request moves it.
          if (start) begin
            r_mode  <= mode;
            r_sel   <= mode ? ch : 2'd0;
            r_data  <= 4'd0;
            r_mask  <= 4'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_data[r_sel] <= z_in;
            r_mask[r_sel] <= 1'b1;
            r_cnt         <= '0;
            // Channel 3 always ends a full scan; the select never wraps to 0.
            if (r_mode || (r_sel == 2'd3)) begin
              r_valid <= 1'b1;
              r_state <= ST_HOLD;
            end else begin
              r_sel   <= r_sel + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_HOLD: begin
          // Word, mask and select stay frozen until the consumer takes the word.
          if (out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign sel       = r_sel;
  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_mask  = r_mask;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed checks of the scan sequencer against a
// behavioural 4:1 MUX, with DWELL=2 for timing tests and DWELL=1/5 builds
// for the exhaustive data/mask sweep.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start_x;
  logic       mode;
  logic [1:0] ch;
  logic       out_ready;
  logic [3:0] mux_in;

  logic [1:0] sel, sel1, sel5;
  logic       busy, busy1, busy5;
  logic       out_valid, out_valid1, out_valid5;
  logic [3:0] out_data, out_data1, out_data5;
  logic [3:0] out_mask, out_mask1, out_mask5;
  logic       z2, z1, z5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 MUX in front of each sequencer.
  assign z2 = mux_in[sel];
  assign z1 = mux_in[sel1];
  assign z5 = mux_in[sel5];

  mux_scan_sequencer #(.DWELL(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ch(ch), .z_in(z2),
    .sel(sel), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask));

  mux_scan_sequencer #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .mode(mode), .ch(ch), .z_in(z1),
    .sel(sel1), .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_mask(out_mask1));

  mux_scan_sequencer #(.DWELL(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .mode(mode), .ch(ch), .z_in(z5),
    .sel(sel5), .busy(busy5), .out_valid(out_valid5), .out_ready(out_ready),
    .out_data(out_data5), .out_mask(out_mask5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start; returns just after the accepting edge (edge 0).
  task automatic launch(input logic m, input logic [1:0] c);
    start = 1'b1;
    mode  = m;
    ch    = c;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({sel, busy, out_valid, out_data, out_mask} !== 12'd0) begin
      errors++;
      $display("FAIL reset_init got sel=%0d busy=%b valid=%b data=%b mask=%b want all 0",
               sel, busy, out_valid, out_data, out_mask);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    mux_in = 4'b1111;
    launch(1'b0, 2'd0);
    tick(); tick(); tick();
    checks++;
    if ({sel, busy, out_mask} !== {2'd1, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL reset_pre got sel=%0d busy=%b mask=%b want sel=1 busy=1 mask=0001",
               sel, busy, out_mask);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel, busy, out_valid, out_data, out_mask} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async got sel=%0d busy=%b valid=%b data=%b mask=%b want all 0",
               sel, busy, out_valid, out_data, out_mask);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sel, busy, out_valid, out_data, out_mask} !== 12'd0) begin
      errors++;
      $display("FAIL reset_held got sel=%0d busy=%b valid=%b data=%b mask=%b want all 0",
               sel, busy, out_valid, out_data, out_mask);
    end
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_after got busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_full_scan();
    logic [1:0] exp_sel;
    mux_in = 4'b1010;
    launch(1'b0, 2'd0);
    checks++;
    if ({sel, busy, out_valid} !== {2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_edge0 got sel=%0d busy=%b valid=%b want 0 1 0", sel, busy, out_valid);
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_sel = (e / 2 > 3) ? 2'd3 : 2'(e / 2);
      checks++;
      if ({sel, busy, out_valid} !== {exp_sel, 1'b1, (e >= 8)}) begin
        errors++;
        $display("FAIL full_edge%0d got sel=%0d busy=%b valid=%b want sel=%0d busy=1 valid=%b",
                 e, sel, busy, out_valid, exp_sel, (e >= 8));
      end
    end
    checks++;
    if ({out_data, out_mask} !== {4'b1010, 4'hF}) begin
      errors++;
      $display("FAIL full_word got data=%b mask=%b want 1010 1111", out_data, out_mask);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL full_accept got busy=%b valid=%b want 0 0", busy, out_valid);
    end
    tick();
  endtask

  task automatic test_single();
    mux_in = 4'b0100;
    launch(1'b1, 2'd2);
    checks++;
    if ({sel, busy, out_valid} !== {2'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_edge0 got sel=%0d busy=%b valid=%b want 2 1 0", sel, busy, out_valid);
    end
    tick();
    checks++;
    if ({sel, out_valid} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL single_edge1 got sel=%0d valid=%b want 2 0", sel, out_valid);
    end
    tick();
    checks++;
    if ({sel, out_valid, out_data, out_mask} !== {2'd2, 1'b1, 4'b0100, 4'b0100}) begin
      errors++;
      $display("FAIL single_word got sel=%0d valid=%b data=%b mask=%b want 2 1 0100 0100",
               sel, out_valid, out_data, out_mask);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    mux_in = 4'b0110;
    launch(1'b0, 2'd0);
    repeat (8) tick();
    for (int i = 0; i < 10; i++) begin
      mux_in = ~mux_in;
      start  = ~start;
      tick();
      checks++;
      if ({sel, busy, out_valid, out_data, out_mask} !== {2'd3, 1'b1, 1'b1, 4'b0110, 4'hF}) begin
        errors++;
        $display("FAIL bp_hold%0d got sel=%0d busy=%b valid=%b data=%b mask=%b want 3 1 1 0110 1111",
                 i, sel, busy, out_valid, out_data, out_mask);
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_release got busy=%b valid=%b want 0 0", busy, out_valid);
    end
    tick();
    checks++;
    if ({sel, busy} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL bp_idle_sel got sel=%0d busy=%b want 3 0", sel, busy);
    end
  endtask

  task automatic test_mid_change();
    mux_in = 4'b0010;
    launch(1'b1, 2'd1);
    mode = 1'b0;
    ch   = 2'd3;
    tick(); tick();
    checks++;
    if ({sel, out_valid, out_data, out_mask} !== {2'd1, 1'b1, 4'b0010, 4'b0010}) begin
      errors++;
      $display("FAIL mid_word got sel=%0d valid=%b data=%b mask=%b want 1 1 0010 0010",
               sel, out_valid, out_data, out_mask);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL mid_hold_start got busy=%b valid=%b want 0 0", busy, out_valid);
    end
    tick();
    checks++;
    if ({sel, busy} !== {2'd1, 1'b0}) begin
      errors++;
      $display("FAIL mid_still_idle got sel=%0d busy=%b want 1 0", sel, busy);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] exp_mask;
    for (int m = 0; m < 5; m++) begin
      for (int v = 0; v < 16; v++) begin
        mux_in   = 4'(v);
        exp_mask = (m == 4) ? 4'hF : (4'b0001 << m);
        start_x  = 1'b1;
        mode     = (m != 4);
        ch       = 2'(m);
        tick();
        start_x  = 1'b0;
        for (int c = 0; c < 100 && !(out_valid1 && out_valid5); c++) tick();
        checks++;
        if (!(out_valid1 && out_valid5)) begin
          errors++;
          $display("FAIL exh_timeout m=%0d v=%0d got valid1=%b valid5=%b want 1 1",
                   m, v, out_valid1, out_valid5);
        end
        checks++;
        if ({out_data1, out_mask1} !== {mux_in & exp_mask, exp_mask}) begin
          errors++;
          $display("FAIL exh_d1 m=%0d v=%0d got data=%b mask=%b want data=%b mask=%b",
                   m, v, out_data1, out_mask1, mux_in & exp_mask, exp_mask);
        end
        checks++;
        if ({out_data5, out_mask5} !== {mux_in & exp_mask, exp_mask}) begin
          errors++;
          $display("FAIL exh_d5 m=%0d v=%0d got data=%b mask=%b want data=%b mask=%b",
                   m, v, out_data5, out_mask5, mux_in & exp_mask, exp_mask);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    start_x   = 1'b0;
    mode      = 1'b0;
    ch        = 2'd0;
    out_ready = 1'b0;
    mux_in    = 4'd0;
    test_reset();
    test_full_scan();
    test_single();
    test_backpressure();
    test_mid_change();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
